// File: rtl/chacha_pkg.sv
// Shared types and constants for the chacha keystream sequencer.
package chacha_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLdKey,
    StLdNnc,
    StLdCtr,
    StWaitLo,
    StWaitRdy,
    StRead
  } state_e;

  typedef enum logic [1:0] {
    SecKey,
    SecNnc,
    SecCtr
  } sec_e;

  localparam int unsigned KEY_BYTES = 32;
  localparam int unsigned NNC_BYTES = 8;
  localparam int unsigned CTR_BYTES = 8;
  localparam int unsigned BLK_BYTES = 64;

  localparam logic [5:0] KEY_BASE = 6'd0;
  localparam logic [5:0] NNC_BASE = 6'd32;
  localparam logic [5:0] CTR_BASE = 6'd40;

  // Bank byte address for a section-relative index.
  function automatic logic [5:0] sec_addr(input sec_e sec, input logic [4:0] idx);
    logic [5:0] addr;
    unique case (sec)
      SecKey:  addr = KEY_BASE + {1'b0, idx};
      SecNnc:  addr = NNC_BASE + {3'b000, idx[2:0]};
      SecCtr:  addr = CTR_BASE + {3'b000, idx[2:0]};
      default: addr = '0;
    endcase
    return addr;
  endfunction

endpackage

// File: rtl/chacha_cfg_bank.sv
// Host-written 48-byte configuration bank: key, nonce and initial block counter.
module chacha_cfg_bank
  import chacha_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [5:0]  addr,
  input  logic [7:0]  wdata,
  input  sec_e        rd_sec,
  input  logic [4:0]  rd_idx,
  output logic [7:0]  rd_data,
  output logic [63:0] ctr
);

  localparam int unsigned BankBytes = KEY_BYTES + NNC_BYTES + CTR_BYTES;

  logic [7:0] mem_q [BankBytes];
  logic [5:0] rd_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BankBytes; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we && (addr < 6'(BankBytes))) begin
      mem_q[addr] <= wdata;
    end
  end

  always_comb begin
    rd_addr = sec_addr(rd_sec, rd_idx);
    rd_data = (rd_addr < 6'(BankBytes)) ? mem_q[rd_addr] : '0;
  end

  // Whole counter exposed at once so a start can copy it in a single cycle.
  always_comb begin
    ctr = '0;
    for (int i = 0; i < CTR_BYTES; i++) begin
      ctr[8*i +: 8] = mem_q[int'(CTR_BASE) + i];
    end
  end

endmodule

// File: rtl/chacha_sequencer.sv
// Run controller for the chacha keystream core: loads key/nonce/counter, waits for
// each block and streams its 64 bytes, auto-incrementing the block counter.
module chacha_sequencer
  import chacha_pkg::*;
#(
  parameter int unsigned NBLK_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [5:0]        cfg_addr,
  input  logic [7:0]        cfg_data,
  input  logic              start,
  input  logic [NBLK_W-1:0] nblk,
  input  logic              stop,
  input  logic              pause,
  output logic              busy,
  output logic              done,
  output logic              err_wrap,
  output logic              core_wr_key,
  output logic              core_wr_nnc,
  output logic              core_wr_ctr,
  output logic              core_hold,
  output logic              core_rd_blk,
  output logic [7:0]        core_data_in,
  input  logic              core_blk_ready,
  input  logic [7:0]        core_data_out,
  output logic              ks_valid,
  output logic [7:0]        ks_data,
  output logic              ks_first,
  output logic              ks_last
);

  localparam logic [5:0] KeyLast = 6'(KEY_BYTES - 1);
  localparam logic [5:0] NncLast = 6'(NNC_BYTES - 1);
  localparam logic [5:0] CtrLast = 6'(CTR_BYTES - 1);
  localparam logic [5:0] BlkLast = 6'(BLK_BYTES - 1);

  state_e             state_q, state_d;
  logic [5:0]         idx_q, idx_d;
  logic [NBLK_W-1:0]  rem_q, rem_d;
  logic               cont_q, cont_d;
  logic               stop_q, stop_d;
  logic [63:0]        work_ctr_q, work_ctr_d;
  logic               err_q, err_d;
  logic               done_q, done_d;
  logic               wr_key_q, wr_key_d;
  logic               wr_nnc_q, wr_nnc_d;
  logic               wr_ctr_q, wr_ctr_d;
  logic               rd_blk_q, rd_blk_d;
  logic               ks_valid_q, ks_valid_d;
  logic [7:0]         ks_data_q, ks_data_d;
  logic               ks_first_q, ks_first_d;
  logic               ks_last_q, ks_last_d;

  logic               wrap;
  logic               finish;
  sec_e               bank_sec;
  logic [7:0]         bank_rd;
  logic [63:0]        bank_ctr;

  // Bank writes are locked out for the whole run; the working counter is separate.
  chacha_cfg_bank u_cfg_bank (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (cfg_we && (state_q == StIdle)),
    .addr    (cfg_addr),
    .wdata   (cfg_data),
    .rd_sec  (bank_sec),
    .rd_idx  (idx_q[4:0]),
    .rd_data (bank_rd),
    .ctr     (bank_ctr)
  );

  assign bank_sec = (state_q == StLdNnc) ? SecNnc : SecKey;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    rem_d      = rem_q;
    cont_d     = cont_q;
    stop_d     = stop_q;
    work_ctr_d = work_ctr_q;
    err_d      = err_q;
    done_d     = 1'b0;
    wr_key_d   = 1'b0;
    wr_nnc_d   = 1'b0;
    wr_ctr_d   = 1'b0;
    rd_blk_d   = 1'b0;
    ks_valid_d = 1'b0;
    ks_data_d  = ks_data_q;
    ks_first_d = 1'b0;
    ks_last_d  = 1'b0;
    wrap       = 1'b0;
    finish     = 1'b0;

    if ((state_q != StIdle) && stop) begin
      stop_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StLdKey;
          idx_d      = '0;
          rem_d      = nblk;
          cont_d     = (nblk == '0);
          stop_d     = stop;
          work_ctr_d = bank_ctr;
          err_d      = 1'b0;
          wr_key_d   = 1'b1;
        end
      end
      StLdKey: begin
        if (idx_q == KeyLast) begin
          state_d  = StLdNnc;
          idx_d    = '0;
          wr_nnc_d = 1'b1;
        end else begin
          idx_d = idx_q + 6'd1;
        end
      end
      StLdNnc: begin
        if (idx_q == NncLast) begin
          state_d  = StLdCtr;
          idx_d    = '0;
          wr_ctr_d = 1'b1;
        end else begin
          idx_d = idx_q + 6'd1;
        end
      end
      StLdCtr: begin
        if (idx_q == CtrLast) begin
          state_d = StWaitLo;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 6'd1;
        end
      end
      // Ready must be seen low first so a ready left over from the previous block is ignored.
      StWaitLo: begin
        if (!core_blk_ready) begin
          state_d = StWaitRdy;
        end
      end
      StWaitRdy: begin
        if (core_blk_ready) begin
          state_d  = StRead;
          idx_d    = '0;
          rd_blk_d = 1'b1;
        end
      end
      StRead: begin
        ks_valid_d = 1'b1;
        ks_data_d  = core_data_out;
        ks_first_d = (idx_q == '0);
        ks_last_d  = (idx_q == BlkLast);
        if (idx_q == BlkLast) begin
          idx_d      = '0;
          wrap       = &work_ctr_q;
          work_ctr_d = work_ctr_q + 64'd1;
          if (!cont_q) begin
            rem_d = rem_q - NBLK_W'(1);
          end
          finish = (!cont_q && (rem_q == NBLK_W'(1))) || stop_q || stop || wrap;
          if (wrap) begin
            err_d = 1'b1;
          end
          if (finish) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            state_d  = StLdCtr;
            wr_ctr_d = 1'b1;
          end
        end else begin
          idx_d = idx_q + 6'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q      <= '0;
      rem_q      <= '0;
      cont_q     <= 1'b0;
      stop_q     <= 1'b0;
      work_ctr_q <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      wr_key_q   <= 1'b0;
      wr_nnc_q   <= 1'b0;
      wr_ctr_q   <= 1'b0;
      rd_blk_q   <= 1'b0;
      ks_valid_q <= 1'b0;
      ks_data_q  <= '0;
      ks_first_q <= 1'b0;
      ks_last_q  <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      rem_q      <= rem_d;
      cont_q     <= cont_d;
      stop_q     <= stop_d;
      work_ctr_q <= work_ctr_d;
      err_q      <= err_d;
      done_q     <= done_d;
      wr_key_q   <= wr_key_d;
      wr_nnc_q   <= wr_nnc_d;
      wr_ctr_q   <= wr_ctr_d;
      rd_blk_q   <= rd_blk_d;
      ks_valid_q <= ks_valid_d;
      ks_data_q  <= ks_data_d;
      ks_first_q <= ks_first_d;
      ks_last_q  <= ks_last_d;
    end
  end

  always_comb begin
    core_data_in = '0;
    unique case (state_q)
      StLdKey: core_data_in = bank_rd;
      StLdNnc: core_data_in = bank_rd;
      StLdCtr: core_data_in = work_ctr_q[{idx_q[2:0], 3'b000} +: 8];
      default: core_data_in = '0;
    endcase
  end

  assign busy        = (state_q != StIdle);
  assign done        = done_q;
  assign err_wrap    = err_q;
  assign core_wr_key = wr_key_q;
  assign core_wr_nnc = wr_nnc_q;
  assign core_wr_ctr = wr_ctr_q;
  assign core_rd_blk = rd_blk_q;
  assign core_hold   = pause && ((state_q == StWaitLo) || (state_q == StWaitRdy));
  assign ks_valid    = ks_valid_q;
  assign ks_data     = ks_data_q;
  assign ks_first    = ks_first_q;
  assign ks_last     = ks_last_q;

endmodule

// File: tb/tb_chacha_sequencer.sv
// Directed bench for chacha_sequencer with a behavioural chacha20 core alongside.
module tb_chacha_sequencer;

  localparam int Lat = 6;

  logic        clk, rst_n;
  logic        cfg_we, start, stop, pause;
  logic [5:0]  cfg_addr;
  logic [7:0]  cfg_data;
  logic [15:0] nblk;
  logic        busy, done, err_wrap;
  logic        core_wr_key, core_wr_nnc, core_wr_ctr, core_hold, core_rd_blk;
  logic [7:0]  core_data_in, core_data_out;
  logic        core_blk_ready;
  logic        ks_valid, ks_first, ks_last;
  logic [7:0]  ks_data;

  chacha_sequencer #(.NBLK_W(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cfg_we         (cfg_we),
    .cfg_addr       (cfg_addr),
    .cfg_data       (cfg_data),
    .start          (start),
    .nblk           (nblk),
    .stop           (stop),
    .pause          (pause),
    .busy           (busy),
    .done           (done),
    .err_wrap       (err_wrap),
    .core_wr_key    (core_wr_key),
    .core_wr_nnc    (core_wr_nnc),
    .core_wr_ctr    (core_wr_ctr),
    .core_hold      (core_hold),
    .core_rd_blk    (core_rd_blk),
    .core_data_in   (core_data_in),
    .core_blk_ready (core_blk_ready),
    .core_data_out  (core_data_out),
    .ks_valid       (ks_valid),
    .ks_data        (ks_data),
    .ks_first       (ks_first),
    .ks_last        (ks_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire [26:0] outs = {busy, done, err_wrap, core_wr_key, core_wr_nnc, core_wr_ctr, core_hold,
                      core_rd_blk, core_data_in, ks_valid, ks_data, ks_first, ks_last};

  // ---------------- reference chacha20 block function ----------------
  function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [511:0] chacha_blk(input logic [255:0] key, input logic [63:0] nnc,
                                              input logic [63:0] ctr);
    logic [31:0] s [16];
    logic [31:0] x [16];
    logic [511:0] r;
    int qt [32] = '{0, 4, 8, 12, 1, 5, 9, 13, 2, 6, 10, 14, 3, 7, 11, 15,
                    0, 5, 10, 15, 1, 6, 11, 12, 2, 7, 8, 13, 3, 4, 9, 14};
    s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
    for (int i = 0; i < 8; i++) s[4+i] = key[32*i +: 32];
    s[12] = ctr[31:0]; s[13] = ctr[63:32]; s[14] = nnc[31:0]; s[15] = nnc[63:32];
    x = s;
    for (int rr = 0; rr < 10; rr++) begin
      for (int q = 0; q < 8; q++) begin
        int a, b, c, d;
        a = qt[4*q]; b = qt[4*q+1]; c = qt[4*q+2]; d = qt[4*q+3];
        x[a] = x[a] + x[b]; x[d] = rotl(x[d] ^ x[a], 16);
        x[c] = x[c] + x[d]; x[b] = rotl(x[b] ^ x[c], 12);
        x[a] = x[a] + x[b]; x[d] = rotl(x[d] ^ x[a], 8);
        x[c] = x[c] + x[d]; x[b] = rotl(x[b] ^ x[c], 7);
      end
    end
    for (int i = 0; i < 16; i++) r[32*i +: 32] = x[i] + s[i];
    return r;
  endfunction

  // ---------------- behavioural core ----------------
  logic [255:0] m_key;
  logic [63:0]  m_nnc, m_ctr;
  logic [511:0] m_blk;
  logic         m_ready, m_reading;
  int           m_mode, m_cnt, m_lat, m_rd;
  int           key_loads, ctr_loads, key_len;
  logic [63:0]  ctr_vals [$];

  assign core_blk_ready = m_ready;
  assign core_data_out  = m_blk[8*m_rd +: 8];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_cnt = 0; m_lat = -1; m_reading = 1'b0;
      m_ready <= 1'b0; m_rd <= 0; m_blk <= '0;
    end else begin
      if (m_lat > 0 && !core_hold) m_lat = m_lat - 1;
      if (m_lat == 0) begin
        m_ready <= 1'b1;
        m_lat = -1;
      end
      if (core_wr_key || core_wr_nnc || core_wr_ctr) begin
        m_ready <= 1'b0;
        m_lat = -1;
        m_cnt = 1;
        if (core_wr_key) begin m_mode = 1; m_key[7:0] = core_data_in; key_loads++; end
        if (core_wr_nnc) begin m_mode = 2; m_nnc[7:0] = core_data_in; end
        if (core_wr_ctr) begin m_mode = 3; m_ctr[7:0] = core_data_in; ctr_loads++; end
      end else if (m_mode != 0) begin
        if (m_mode == 1) m_key[8*m_cnt +: 8] = core_data_in;
        if (m_mode == 2) m_nnc[8*m_cnt +: 8] = core_data_in;
        if (m_mode == 3) m_ctr[8*m_cnt +: 8] = core_data_in;
        if (m_cnt == ((m_mode == 1) ? 31 : 7)) begin
          if (m_mode == 1) key_len = m_cnt + 1;
          if (m_mode == 3) begin
            m_blk <= chacha_blk(m_key, m_nnc, m_ctr);
            ctr_vals.push_back(m_ctr);
            m_lat = Lat;
          end
          m_mode = 0;
        end else begin
          m_cnt++;
        end
      end
      if (core_rd_blk) begin
        m_rd <= 1;
        m_reading = 1'b1;
      end else if (m_reading) begin
        if (m_rd == 63) begin m_rd <= 0; m_reading = 1'b0; end
        else m_rd <= m_rd + 1;
      end
    end
  end

  // ---------------- keystream monitor ----------------
  logic [7:0] ks_q [$];
  int         first_q [$];
  int         last_q [$];
  int         done_cnt;

  always @(negedge clk) begin
    if (ks_valid) begin
      if (ks_first) first_q.push_back(ks_q.size());
      if (ks_last) last_q.push_back(ks_q.size());
      ks_q.push_back(ks_data);
    end
    if (done) done_cnt++;
  end

  // ---------------- checking ----------------
  int n_chk, n_pass;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic clr();
    ks_q.delete(); first_q.delete(); last_q.delete(); ctr_vals.delete();
    done_cnt = 0; key_loads = 0; ctr_loads = 0; key_len = 0;
  endtask

  task automatic cfg_wr(input logic [5:0] a, input logic [7:0] d);
    cfg_addr = a; cfg_data = d; cfg_we = 1'b1;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic do_start(input logic [15:0] n);
    nblk = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int base, n;
    base = done_cnt; n = 0;
    while (done_cnt == base && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(done_cnt != base), 64'd1);
    repeat (2) @(negedge clk);
  endtask

  function automatic logic [63:0] first8(input int base);
    logic [63:0] v = '0;
    for (int i = 0; i < 8; i++) v = {v[55:0], ks_q[base+i]};
    return v;
  endfunction

  function automatic int blk_bad(input int base, input logic [511:0] exp);
    int bad = 0;
    for (int i = 0; i < 64; i++) if (ks_q[base+i] !== exp[8*i +: 8]) bad++;
    return bad;
  endfunction

  initial begin
    int n;
    n_chk = 0; n_pass = 0;
    rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    start = 1'b0; stop = 1'b0; pause = 1'b0; nblk = '0;
    clr();
    repeat (2) @(negedge clk);
    check("rst_outs", 64'(outs), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_outs", 64'(outs), 64'd0);

    // single block, all-zero configuration
    clr();
    do_start(16'd1);
    wait_done("t1_done", 400);
    check("t1_count", 64'(ks_q.size()), 64'd64);
    if (ks_q.size() >= 64) begin
      check("t1_first8", first8(0), 64'h76b8e0ada0f13d90);
      check("t1_block", 64'(blk_bad(0, chacha_blk('0, '0, 64'd0))), 64'd0);
    end
    check("t1_first", {32'(first_q.size()), 32'(first_q.size() > 0 ? first_q[0] : -1)},
          {32'd1, 32'd0});
    check("t1_last", {32'(last_q.size()), 32'(last_q.size() > 0 ? last_q[0] : -1)},
          {32'd1, 32'd63});
    check("t1_done_cnt", 64'(done_cnt), 64'd1);
    check("t1_busy", 64'(busy), 64'd0);

    // two blocks: counter reload only
    clr();
    do_start(16'd2);
    wait_done("t2_done", 800);
    check("t2_count", 64'(ks_q.size()), 64'd128);
    if (ks_q.size() >= 128) begin
      check("t2_first8_b1", first8(64), 64'h9f07e7be5551387a);
      check("t2_block1", 64'(blk_bad(64, chacha_blk('0, '0, 64'd1))), 64'd0);
    end
    check("t2_loads", {32'(key_loads), 32'(ctr_loads)}, {32'd1, 32'd2});
    if (ctr_vals.size() == 2) begin
      check("t2_ctr0", ctr_vals[0], 64'd0);
      check("t2_ctr1", ctr_vals[1], 64'd1);
    end
    check("t2_done_cnt", 64'(done_cnt), 64'd1);

    // counter wrap in continuous mode
    clr();
    for (int i = 0; i < 8; i++) cfg_wr(6'(40 + i), 8'hff);
    do_start(16'd0);
    wait_done("t3_done", 600);
    check("t3_count", 64'(ks_q.size()), 64'd64);
    if (ks_q.size() >= 64)
      check("t3_block", 64'(blk_bad(0, chacha_blk('0, '0, 64'hffff_ffff_ffff_ffff))), 64'd0);
    check("t3_err", 64'(err_wrap), 64'd1);
    check("t3_done_cnt", 64'(done_cnt), 64'd1);
    for (int i = 0; i < 8; i++) cfg_wr(6'(40 + i), 8'h00);
    clr();
    do_start(16'd1);
    check("t3_err_clr", 64'(err_wrap), 64'd0);
    wait_done("t3b_done", 400);
    check("t3b_err", 64'(err_wrap), 64'd0);

    // continuous run stopped during block 3
    clr();
    do_start(16'd0);
    n = 0;
    while (ks_q.size() < 160 && n < 2000) begin @(negedge clk); n++; end
    check("t4_reach", 64'(ks_q.size() >= 160), 64'd1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    wait_done("t4_done", 600);
    check("t4_count", 64'(ks_q.size()), 64'd192);
    check("t4_ctr_loads", 64'(ctr_loads), 64'd3);
    check("t4_err", 64'(err_wrap), 64'd0);

    // bank write while busy, pause during wait
    clr();
    pause = 1'b1;
    do_start(16'd1);
    cfg_wr(6'd0, 8'hff);
    n = 0;
    while (!core_wr_ctr && n < 200) begin @(negedge clk); n++; end
    check("t5_wr_ctr_seen", 64'(core_wr_ctr), 64'd1);
    check("t5_hold_ld", 64'(core_hold), 64'd0);
    repeat (12) @(negedge clk);
    check("t5_hold_wait", {63'd0, core_hold}, 64'd1);
    check("t5_frozen", 64'(ks_valid), 64'd0);
    pause = 1'b0;
    n = 0;
    while (!ks_valid && n < 100) begin @(negedge clk); n++; end
    pause = 1'b1;
    @(negedge clk);
    check("t5_hold_read", {63'd0, ks_valid, core_hold}, 64'd2);
    pause = 1'b0;
    wait_done("t5_done", 200);
    clr();
    do_start(16'd1);
    wait_done("t5b_done", 400);
    check("t5_key0", 64'(m_key[7:0]), 64'd0);
    if (ks_q.size() >= 64) check("t5b_block", 64'(blk_bad(0, chacha_blk('0, '0, 64'd0))), 64'd0);

    // asynchronous reset during key load
    clr();
    do_start(16'd1);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("t6_rst_async", 64'(outs), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clr();
    do_start(16'd1);
    wait_done("t6_done", 400);
    check("t6_key_load", {32'(key_loads), 32'(key_len)}, {32'd1, 32'd32});
    check("t6_count", 64'(ks_q.size()), 64'd64);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
